// File: rtl/track_pos_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : track_pos_ctrl_pkg
// Description : Shared definitions for the track position controller and the
//               track stepper driver: step half-period formula, controller
//               state encoding and the homing travel margin.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package track_pos_ctrl_pkg;

    // System clock cycles per millisecond at 50 MHz, halved because the
    // divider counts half step periods.
    localparam int unsigned CYCLES_PER_MS = 25000;

    // Extra steps allowed beyond full travel before homing is declared failed.
    localparam int unsigned HOME_MARGIN = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOMING = 2'd1,
        ST_MOVE   = 2'd2,
        ST_SETTLE = 2'd3
    } state_e;

    // Step half-period in system clock cycles; the driver's divider uses the
    // same formula so both dividers stay phase-locked from reset.
    function automatic int unsigned half_period_cycles(input int unsigned speed_ms);
        return CYCLES_PER_MS * speed_ms;
    endfunction

endpackage
`default_nettype wire

// File: rtl/track_pos_ctrl_step_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : step_tick_gen
// Description : Step-period divider matching the stepper driver's divider.
//               A half-period counter (0..HALF_CYC-1) plus a phase bit; tick
//               fires on the wrap cycle while the phase bit is low, i.e. the
//               cycle before the driver's divided clock rises.
// Ports       : clk   - system clock
//               rst_n - asynchronous active-low reset
//               tick  - one-cycle pulse once per step period
// Revision    : 1.0 - initial release
// ============================================================================
module step_tick_gen
    import track_pos_ctrl_pkg::*;
#(
    parameter int unsigned SPEED_MS = 10,
    parameter int unsigned HALF_CYC = half_period_cycles(SPEED_MS)
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned        c_cnt_w    = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(HALF_CYC - 1);

    logic [c_cnt_w-1:0] cnt_q;
    logic               phase_q;
    logic               w_wrap;

    assign w_wrap = (cnt_q == c_cnt_last);
    assign tick   = w_wrap & ~phase_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (w_wrap) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
        end else begin
            cnt_q   <= cnt_q + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/track_pos_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : track_pos_ctrl
// Description : Position controller in front of the track stepper driver.
//               Accepts absolute step targets and homing requests, drives the
//               driver's move/back inputs for the exact number of step periods
//               and tracks the carriage position.
// Ports       : clk, rst_n          - 50 MHz clock, async active-low reset
//               cmd_valid_i/ready_o - target command handshake
//               cmd_pos_i           - absolute target in steps
//               home_i              - one-cycle homing request
//               home_sw_i           - async home limit switch
//               move_o, back_o      - driver controls (back = toward home)
//               pos_o, homed_o      - current position and its validity
//               busy_o, done_o      - not-idle flag, completion pulse
//               err_o               - sticky homing failure
// Revision    : 1.0 - initial release
// ============================================================================
module track_pos_ctrl
    import track_pos_ctrl_pkg::*;
#(
    parameter int unsigned SPEED_MS     = 10,
    parameter int unsigned POS_W        = 12,
    parameter int unsigned MAX_POS      = 2000,
    parameter int unsigned SETTLE_STEPS = 4,
    parameter int unsigned HALF_CYC     = half_period_cycles(SPEED_MS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [POS_W-1:0] cmd_pos_i,
    input  logic             home_i,
    input  logic             home_sw_i,
    output logic             move_o,
    output logic             back_o,
    output logic [POS_W-1:0] pos_o,
    output logic             homed_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    localparam int unsigned          c_hcnt_w      = $clog2(MAX_POS + HOME_MARGIN + 1);
    localparam logic [c_hcnt_w-1:0]  c_home_limit  = c_hcnt_w'(MAX_POS + HOME_MARGIN);
    localparam logic [POS_W-1:0]     c_max_pos     = POS_W'(MAX_POS);
    // SETTLE_STEPS must be at least 1.
    localparam int unsigned          c_scnt_w      = (SETTLE_STEPS > 1) ? $clog2(SETTLE_STEPS) : 1;
    localparam logic [c_scnt_w-1:0]  c_settle_last = c_scnt_w'(SETTLE_STEPS - 1);

    state_e              state_q, state_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic [POS_W-1:0]    target_q, target_d;
    logic [c_hcnt_w-1:0] home_cnt_q, home_cnt_d;
    logic [c_scnt_w-1:0] settle_cnt_q, settle_cnt_d;
    logic                homed_q, homed_d;
    logic                err_q, err_d;
    logic                done_q, done_d;
    logic                move_q, move_d;
    logic                back_q, back_d;
    logic                sw_meta_q, sw_sync_q;

    logic                w_tick;
    logic                w_accept;
    logic [POS_W-1:0]    w_target;
    logic [POS_W-1:0]    w_step_pos;
    logic [c_hcnt_w-1:0] w_home_cnt_inc;

    step_tick_gen #(
        .SPEED_MS (SPEED_MS),
        .HALF_CYC (HALF_CYC)
    ) u_step_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    // A simultaneous homing request takes priority, so the command is not
    // handshaken in that cycle.
    assign cmd_ready_o    = (state_q == ST_IDLE) & homed_q & ~home_i;
    assign w_accept       = cmd_valid_i & cmd_ready_o;
    assign w_target       = (cmd_pos_i > c_max_pos) ? c_max_pos : cmd_pos_i;
    assign w_step_pos     = back_q ? (pos_q - 1'b1) : (pos_q + 1'b1);
    assign w_home_cnt_inc = home_cnt_q + 1'b1;

    assign move_o  = move_q;
    assign back_o  = back_q;
    assign pos_o   = pos_q;
    assign homed_o = homed_q;
    assign busy_o  = (state_q != ST_IDLE);
    assign done_o  = done_q;
    assign err_o   = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta_q <= 1'b0;
            sw_sync_q <= 1'b0;
        end else begin
            sw_meta_q <= home_sw_i;
            sw_sync_q <= sw_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pos_q        <= '0;
            target_q     <= '0;
            home_cnt_q   <= '0;
            settle_cnt_q <= '0;
            homed_q      <= 1'b0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            move_q       <= 1'b0;
            back_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            target_q     <= target_d;
            home_cnt_q   <= home_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            homed_q      <= homed_d;
            err_q        <= err_d;
            done_q       <= done_d;
            move_q       <= move_d;
            back_q       <= back_d;
        end
    end

    // move/back only ever change on a tick, so the driver sees them settled
    // for at least half a step period. The first tick of HOMING/MOVE only
    // raises move; each later tick corresponds to one completed step.
    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        target_d     = target_q;
        home_cnt_d   = home_cnt_q;
        settle_cnt_d = settle_cnt_q;
        homed_d      = homed_q;
        err_d        = err_q;
        done_d       = 1'b0;
        move_d       = move_q;
        back_d       = back_q;

        case (state_q)
            ST_IDLE: begin
                if (home_i) begin
                    state_d    = ST_HOMING;
                    err_d      = 1'b0;
                    homed_d    = 1'b0;
                    home_cnt_d = '0;
                end else if (w_accept) begin
                    if (w_target == pos_q) begin
                        done_d = 1'b1;
                    end else begin
                        target_d = w_target;
                        state_d  = ST_MOVE;
                    end
                end
            end

            ST_HOMING: begin
                if (w_tick) begin
                    if (sw_sync_q) begin
                        pos_d        = '0;
                        homed_d      = 1'b1;
                        move_d       = 1'b0;
                        settle_cnt_d = '0;
                        state_d      = ST_SETTLE;
                    end else if (!move_q) begin
                        move_d = 1'b1;
                        back_d = 1'b1;
                    end else begin
                        home_cnt_d = w_home_cnt_inc;
                        if (w_home_cnt_inc == c_home_limit) begin
                            err_d        = 1'b1;
                            move_d       = 1'b0;
                            settle_cnt_d = '0;
                            state_d      = ST_SETTLE;
                        end
                    end
                end
            end

            ST_MOVE: begin
                if (w_tick) begin
                    if (!move_q) begin
                        move_d = 1'b1;
                        back_d = (target_q < pos_q);
                    end else begin
                        pos_d = w_step_pos;
                        if (w_step_pos == target_q) begin
                            move_d       = 1'b0;
                            settle_cnt_d = '0;
                            state_d      = ST_SETTLE;
                        end
                    end
                end
            end

            ST_SETTLE: begin
                if (w_tick) begin
                    if (settle_cnt_q == c_settle_last) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 1'b1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_track_pos_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_track_pos_ctrl
// Description : Self-checking bench for track_pos_ctrl with a 4-cycle half
//               period (8-cycle step period), MAX_POS=20, SETTLE_STEPS=2.
//               Expected completions are queued by the stimulus and checked
//               by an independent monitor on every done_o pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_track_pos_ctrl;

    localparam int unsigned POS_W  = 12;
    localparam int          PERIOD = 8;   // cycles per step period

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic [POS_W-1:0] cmd_pos_i;
    logic             home_i;
    logic             home_sw_i;
    logic             move_o;
    logic             back_o;
    logic [POS_W-1:0] pos_o;
    logic             homed_o;
    logic             busy_o;
    logic             done_o;
    logic             err_o;

    track_pos_ctrl #(
        .SPEED_MS     (1),
        .POS_W        (POS_W),
        .MAX_POS      (20),
        .SETTLE_STEPS (2),
        .HALF_CYC     (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_pos_i   (cmd_pos_i),
        .home_i      (home_i),
        .home_sw_i   (home_sw_i),
        .move_o      (move_o),
        .back_o      (back_o),
        .pos_o       (pos_o),
        .homed_o     (homed_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int moves;    // step periods with move_o high
        bit back;
        bit chk_pos;
        int pos;
        bit homed;
        bit err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int moves, input bit back, input bit chk_pos,
                        input int pos, input bit homed, input bit err);
        exp_t e;
        e.moves = moves; e.back = back; e.chk_pos = chk_pos;
        e.pos = pos; e.homed = homed; e.err = err;
        sb.push_back(e);
    endtask

    // ---------------- monitor ----------------
    int               mv_cycles = 0;
    bit               mv_back   = 1'b0;
    logic [POS_W-1:0] prev_pos  = '0;
    bit               prev_homed = 1'b0;
    bit               prev_done  = 1'b0;
    exp_t             m_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            mv_cycles  = 0;
            prev_homed = 1'b0;
            prev_done  = 1'b0;
            prev_pos   = '0;
        end else begin
            if (move_o) begin
                mv_cycles++;
                mv_back = back_o;
            end
            if (prev_homed && homed_o && pos_o != prev_pos)
                chk("step", 32'(pos_o), back_o ? 32'(prev_pos - 1'b1) : 32'(prev_pos + 1'b1));
            if (prev_done)
                chk("done_width", 32'(done_o), 0);
            if (done_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    m_e = sb.pop_front();
                    chk("move_cycles", mv_cycles, m_e.moves * PERIOD);
                    if (m_e.moves > 0) chk("back_dir", 32'(mv_back), 32'(m_e.back));
                    if (m_e.chk_pos)   chk("pos_done", 32'(pos_o), m_e.pos);
                    chk("homed_done", 32'(homed_o), 32'(m_e.homed));
                    chk("err_done", 32'(err_o), 32'(m_e.err));
                    chk("busy_done", 32'(busy_o), 0);
                end
                mv_cycles = 0;
            end
            prev_pos   = pos_o;
            prev_homed = homed_o;
            prev_done  = done_o;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_move_rise(input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 2 * PERIOD + 1; k++) begin
            @(posedge clk); #1;
            if (move_o) begin seen = 1'b1; break; end
        end
        chk(name, 32'(seen), 1);
    endtask

    task automatic wait_done(input string name, input int budget);
        bit ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (sb.size() == 0) begin ok = 1'b1; break; end
        end
        chk(name, 32'(ok), 1);
    endtask

    task automatic issue_cmd(input int p);
        cmd_valid_i = 1'b1;
        cmd_pos_i   = POS_W'(p);
        #1 chk("cmd_ready", 32'(cmd_ready_o), 1);
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic pulse_home();
        home_i = 1'b1;
        @(posedge clk); #1;
        home_i = 1'b0;
    endtask

    // Raise the switch so the synchronised level is seen at the 5th step tick
    // after move_o rose.
    task automatic switch_after_5_steps();
        repeat (5 * PERIOD - 4) @(posedge clk);
        #1 home_sw_i = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid_i = 1'b0; cmd_pos_i = '0;
        home_i = 1'b0; home_sw_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("reset_outputs",
               32'({move_o, back_o, pos_o, homed_o, busy_o, done_o, err_o, cmd_ready_o}), 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;

        // Home: switch seen after 5 steps
        push(5, 1'b1, 1'b1, 0, 1'b1, 1'b0);
        pulse_home();
        chk("home_busy", 32'(busy_o), 1);
        wait_move_rise("home_rise");
        switch_after_5_steps();
        wait_done("home_done", 200);
        chk("ready_after_home", 32'(cmd_ready_o), 1);
        home_sw_i = 1'b0;

        // Forward 0 -> 7
        push(7, 1'b0, 1'b1, 7, 1'b1, 1'b0);
        issue_cmd(7);
        chk("fwd_busy", 32'(busy_o), 1);
        wait_move_rise("fwd_rise");
        wait_done("fwd_done", 300);

        // Backward 7 -> 3
        push(4, 1'b1, 1'b1, 3, 1'b1, 1'b0);
        issue_cmd(3);
        wait_move_rise("back_rise");
        wait_done("back_done", 300);

        // Equal target: immediate done, no motion
        push(0, 1'b0, 1'b1, 3, 1'b1, 1'b0);
        issue_cmd(3);
        chk("equal_done_next", 32'(done_o), 1);
        chk("equal_not_busy", 32'(busy_o), 0);
        wait_done("equal_done", 20);

        // Clamp: 50 -> 20 (17 steps forward)
        push(17, 1'b0, 1'b1, 20, 1'b1, 1'b0);
        issue_cmd(50);
        wait_move_rise("clamp_rise");
        wait_done("clamp_done", 400);

        // Priority: home_i beats a simultaneous command
        push(5, 1'b1, 1'b1, 0, 1'b1, 1'b0);
        cmd_valid_i = 1'b1; cmd_pos_i = POS_W'(10); home_i = 1'b1;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0; home_i = 1'b0;
        chk("prio_homed_cleared", 32'(homed_o), 0);
        wait_move_rise("prio_rise");
        switch_after_5_steps();
        wait_done("prio_done", 200);
        home_sw_i = 1'b0;

        // Homing timeout: switch never seen, 84 steps
        push(84, 1'b1, 1'b0, 0, 1'b0, 1'b1);
        pulse_home();
        wait_move_rise("timeout_rise");
        wait_done("timeout_done", 1000);
        chk("timeout_err", 32'(err_o), 1);
        chk("timeout_homed", 32'(homed_o), 0);
        cmd_valid_i = 1'b1; cmd_pos_i = POS_W'(5);
        #1 chk("unhomed_ready", 32'(cmd_ready_o), 0);
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        repeat (PERIOD * 2) @(posedge clk); #1;
        chk("unhomed_ignored", 32'({busy_o, move_o}), 0);

        // Re-home with switch already active: err cleared, no motion
        home_sw_i = 1'b1;
        repeat (3) @(posedge clk); #1;
        push(0, 1'b1, 1'b1, 0, 1'b1, 1'b0);
        pulse_home();
        chk("err_cleared", 32'(err_o), 0);
        wait_done("rehome_done", 200);
        home_sw_i = 1'b0;

        // Reset in the middle of a move
        issue_cmd(10);
        wait_move_rise("rst_move_rise");
        repeat (20) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk("reset_mid_move",
               32'({move_o, back_o, pos_o, homed_o, busy_o, done_o, err_o, cmd_ready_o}), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (PERIOD * 2) @(posedge clk); #1;
        chk("post_reset_idle", 32'({move_o, homed_o, busy_o, cmd_ready_o}), 0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
